// File: rtl/rgbw_pwm_engine_pkg.sv
// Shared types and constants for the RGBW PWM engine: duty width, period
// length, channel indices and the per-channel phase offset table.
package rgbw_pkg;

  localparam int DUTY_W     = 8;
  localparam int PWM_PERIOD = 255;
  localparam int NUM_CH     = 4;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int CH_W = 3;

  typedef logic [DUTY_W-1:0] duty_t;

  // Quarter-period spacing of the channel phases (index = channel).
  localparam logic [NUM_CH-1:0][DUTY_W-1:0] STAGGER_OFF = {8'd192, 8'd128, 8'd64, 8'd0};

  // Offset for a channel, or zero when staggering is disabled.
  function automatic duty_t phase_offset(input bit stagger, input logic [1:0] ch);
    return stagger ? STAGGER_OFF[ch] : '0;
  endfunction

endpackage

// File: rtl/rgbw_pwm_engine_if.sv
// Duty-update channel from the colour generation stage: four duty values
// qualified by a valid/ready handshake.
interface rgbw_pwm_engine_if;
  import rgbw_pkg::*;

  duty_t duty_r;
  duty_t duty_g;
  duty_t duty_b;
  duty_t duty_w;
  logic  duty_valid;
  logic  duty_ready;

  // Colour source side.
  modport master (
    output duty_r, duty_g, duty_b, duty_w, duty_valid,
    input  duty_ready
  );

  // PWM engine side.
  modport slave (
    input  duty_r, duty_g, duty_b, duty_w, duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/rgbw_pwm_engine_compare_ch.sv
// One PWM channel: active duty register, phase-shifted counter view,
// comparator and the registered, enable-gated output pin.
module pwm_compare_ch
  import rgbw_pkg::*;
#(
  parameter duty_t OFFSET = '0
) (
  input  logic  clk,
  input  logic  reset,
  input  duty_t cnt,
  input  logic  load,
  input  duty_t load_duty,
  input  logic  out_en,
  output logic  pwm
);

  localparam logic [DUTY_W:0] PERIOD_X = (DUTY_W+1)'(PWM_PERIOD);

  duty_t           active_reg;
  logic [DUTY_W:0] phase_sum;
  duty_t           phase;
  logic            pwm_reg;

  // Sum is at most 254 + 254, so one conditional subtract reduces it mod 255.
  assign phase_sum = {1'b0, cnt} + {1'b0, OFFSET};
  assign phase     = (phase_sum >= PERIOD_X) ? duty_t'(phase_sum - PERIOD_X)
                                             : phase_sum[DUTY_W-1:0];

  // Active duty only changes at a period boundary, so every period is whole.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg <= '0;
    end else if (load) begin
      active_reg <= load_duty;
    end
  end

  // Phase never reaches 255, so duty 255 is constantly high and duty 0 constantly low.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_reg <= 1'b0;
    end else begin
      pwm_reg <= out_en && (phase < active_reg);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/rgbw_pwm_engine.sv
// Four-channel RGBW PWM generator. Holds the tick prescaler, the 255-tick
// period counter and the shadow duty registers with their handshake; the
// per-channel compare logic lives in pwm_compare_ch.
module rgbw_pwm_engine
  import rgbw_pkg::*;
#(
  parameter int PRESC_DIV     = 1,   // clk cycles per PWM tick, >= 1
  parameter bit PHASE_STAGGER = 1'b1 // spread channel phases by a quarter period
) (
  input  logic             clk,
  input  logic             reset,
  rgbw_pwm_engine_if.slave duty,
  input  logic             out_en,
  output logic             pwm_r,
  output logic             pwm_g,
  output logic             pwm_b,
  output logic             pwm_w,
  output logic             period_start
);

  localparam int                 PRESC_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
  localparam duty_t              CNT_LAST   = duty_t'(PWM_PERIOD - 1);

  // IDLE: shadow free, ready high. PENDING: shadow holds data awaiting a boundary.
  typedef enum logic {
    HS_IDLE,
    HS_PENDING
  } hs_state_t;

  logic [PRESC_W-1:0] presc_cnt_reg;
  duty_t              cnt_reg;
  logic               period_start_reg;
  hs_state_t          hs_state_reg;
  hs_state_t          hs_state_next;
  logic               shadow_we;
  logic               active_load;
  duty_t              shadow_reg [NUM_CH];
  duty_t              duty_in    [NUM_CH];
  logic [NUM_CH-1:0]  pwm_vec;
  logic               tick;
  logic               boundary;

  assign tick     = (presc_cnt_reg == PRESC_LAST);
  assign boundary = tick && (cnt_reg == CNT_LAST);

  assign duty_in[CH_R] = duty.duty_r;
  assign duty_in[CH_G] = duty.duty_g;
  assign duty_in[CH_B] = duty.duty_b;
  assign duty_in[CH_W] = duty.duty_w;

  // Prescaler: wraps after PRESC_DIV cycles; with PRESC_DIV = 1 it stays 0 and tick is constant.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_reg <= '0;
    end else if (tick) begin
      presc_cnt_reg <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_reg + 1'b1;
    end
  end

  // Period counter 0..254 advancing on tick, with a one-cycle pulse at each wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      period_start_reg <= boundary;
      if (boundary) begin
        cnt_reg <= '0;
      end else if (tick) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_state_reg <= HS_IDLE;
    end else begin
      hs_state_reg <= hs_state_next;
    end
  end

  // Handshake next state: accept into shadow when idle, release to active at a boundary.
  // A transfer in a boundary cycle while idle only fills the shadow, so it waits one period.
  always_comb begin
    hs_state_next = hs_state_reg;
    shadow_we     = 1'b0;
    active_load   = 1'b0;
    case (hs_state_reg)
      HS_IDLE: begin
        if (duty.duty_valid) begin
          shadow_we     = 1'b1;
          hs_state_next = HS_PENDING;
        end
      end
      HS_PENDING: begin
        if (boundary) begin
          active_load   = 1'b1;
          hs_state_next = HS_IDLE;
        end
      end
      default: hs_state_next = HS_IDLE;
    endcase
  end

  assign duty.duty_ready = (hs_state_reg == HS_IDLE);

  // Shadow duty registers, written only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (shadow_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_reg[i] <= duty_in[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwm_compare_ch #(
      .OFFSET(phase_offset(PHASE_STAGGER, 2'(gi)))
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .cnt      (cnt_reg),
      .load     (active_load),
      .load_duty(shadow_reg[gi]),
      .out_en   (out_en),
      .pwm      (pwm_vec[gi])
    );
  end

  assign pwm_r        = pwm_vec[CH_R];
  assign pwm_g        = pwm_vec[CH_G];
  assign pwm_b        = pwm_vec[CH_B];
  assign pwm_w        = pwm_vec[CH_W];
  assign period_start = period_start_reg;

endmodule

// File: tb/tb_rgbw_pwm_engine.sv
// Bench for rgbw_pwm_engine: three instances (aligned, staggered, prescaled by
// 4) share one stimulus stream and are checked every cycle against an
// arithmetic reference model, plus per-period measurements against a table.
`timescale 1ns/1ps
module tb_rgbw_pwm_engine;
  import rgbw_pkg::*;

  localparam int NI = 3;
  localparam int P_DIV [NI] = '{1, 1, 4};
  localparam int P_STG [NI] = '{0, 1, 0};

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       out_en  = 1'b1;
  logic       d_valid = 1'b0;
  logic [7:0] d_in [4];

  logic [3:0] pwm_v [NI];
  logic       ps_v  [NI];
  logic       rdy_v [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    rgbw_pwm_engine_if dif ();
    logic pr, pg, pb, pw, ps;
    assign dif.duty_r     = d_in[0];
    assign dif.duty_g     = d_in[1];
    assign dif.duty_b     = d_in[2];
    assign dif.duty_w     = d_in[3];
    assign dif.duty_valid = d_valid;
    assign pwm_v[gi]      = {pw, pb, pg, pr};
    assign ps_v[gi]       = ps;
    assign rdy_v[gi]      = dif.duty_ready;
    rgbw_pwm_engine #(
      .PRESC_DIV    (P_DIV[gi]),
      .PHASE_STAGGER(P_STG[gi] != 0)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .duty        (dif),
      .out_en      (out_en),
      .pwm_r       (pr),
      .pwm_g       (pg),
      .pwm_b       (pb),
      .pwm_w       (pw),
      .period_start(ps)
    );
  end

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state (per instance).
  int         m_n    [NI];
  bit         m_pend [NI];
  int         m_sh   [NI][4];
  int         m_act  [NI][4];
  logic [3:0] e_pwm  [NI];
  logic       e_ps   [NI];

  // Period measurements taken from the outputs.
  int         acc       [NI][4];
  int         last_cnt  [NI][4];
  int         rise      [NI][4];
  int         last_rise [NI][4];
  int         pos       [NI];
  int         len       [NI];
  int         last_len  [NI];
  int         ps_cnt    [NI];
  logic       ps_prev   [NI];
  logic [3:0] pwm_prev  [NI];

  typedef struct {
    int d    [4];
    int hi   [4];
    int rise [4];
  } vec_t;
  vec_t vt [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
    end
  endtask

  function automatic vec_t mk(input int d0, d1, d2, d3, h0, h1, h2, h3, r0, r1, r2, r3);
    vec_t v;
    v.d    = '{d0, d1, d2, d3};
    v.hi   = '{h0, h1, h2, h3};
    v.rise = '{r0, r1, r2, r3};
    return v;
  endfunction

  // Per-cycle: compare, measure, then advance the model by the coming posedge.
  initial begin
    int c_old;
    bit bnd;
    bit xfer;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (chk_en) begin
          check($sformatf("cycle dut%0d {ready,ps,pwm_wbgr}", i),
                {rdy_v[i], ps_v[i], pwm_v[i]}, {!m_pend[i], e_ps[i], e_pwm[i]});
        end
        if (ps_prev[i] === 1'b1) begin
          for (int k = 0; k < 4; k++) begin
            last_cnt[i][k]  = acc[i][k];
            acc[i][k]       = 0;
            last_rise[i][k] = rise[i][k];
            rise[i][k]      = -1;
          end
          last_len[i] = len[i];
          len[i]      = 0;
          pos[i]      = 0;
        end
        for (int k = 0; k < 4; k++) begin
          if (pwm_v[i][k] === 1'b1) begin
            acc[i][k]++;
            if (pwm_prev[i][k] !== 1'b1 && rise[i][k] == -1) rise[i][k] = pos[i];
          end
        end
        pos[i]++;
        len[i]++;
        if (ps_v[i] === 1'b1) ps_cnt[i]++;
        ps_prev[i]  = ps_v[i];
        pwm_prev[i] = pwm_v[i];

        if (reset) begin
          m_n[i]    = 0;
          m_pend[i] = 1'b0;
          e_pwm[i]  = 4'b0000;
          e_ps[i]   = 1'b0;
          for (int k = 0; k < 4; k++) begin
            m_sh[i][k]  = 0;
            m_act[i][k] = 0;
            rise[i][k]  = -1;
          end
        end else begin
          // m_n clocks since reset: counter = floor(m_n / P) mod 255.
          c_old = (m_n[i] / P_DIV[i]) % 255;
          for (int k = 0; k < 4; k++) begin
            e_pwm[i][k] = out_en && (((c_old + (P_STG[i] != 0 ? 64 * k : 0)) % 255) < m_act[i][k]);
          end
          bnd  = ((m_n[i] + 1) % (255 * P_DIV[i])) == 0;
          xfer = d_valid && !m_pend[i];
          m_n[i]++;
          e_ps[i] = bnd;
          if (bnd && m_pend[i]) begin
            for (int k = 0; k < 4; k++) m_act[i][k] = m_sh[i][k];
            m_pend[i] = 1'b0;
          end
          if (xfer) begin
            for (int k = 0; k < 4; k++) m_sh[i][k] = d_in[k];
            m_pend[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int r, input int g, input int b, input int w);
    int guard = 0;
    while (!rdy_v[0] && guard < 3000) begin
      cyc(1);
      guard++;
    end
    check("send: dut0 ready within bound", rdy_v[0], 1);
    d_in[0] = 8'(r);
    d_in[1] = 8'(g);
    d_in[2] = 8'(b);
    d_in[3] = 8'(w);
    d_valid = 1'b1;
    cyc(1);
    d_valid = 1'b0;
    $display("xfer t=%0t duty r/g/b/w=%0d/%0d/%0d/%0d", $time, r, g, b, w);
  endtask

  task automatic wait_ps(input int i, input int n);
    int target = ps_cnt[i] + n;
    int guard  = 0;
    while (ps_cnt[i] < target && guard < 1100 * (n + 1)) begin
      cyc(1);
      guard++;
    end
    check($sformatf("dut%0d period_start count reached", i), ps_cnt[i] >= target, 1);
  endtask

  initial begin
    int nacc;
    int last_val;
    int v8;

    vt[0] = mk(0, 255, 128, 64,   0, 255, 128, 64,   -1, -1, 0, 0);
    vt[1] = mk(1, 254, 17, 200,   1, 254, 17, 200,    0, 0, 0, 0);
    vt[2] = mk(255, 0, 200, 1,    255, 0, 200, 1,    -1, -1, 0, 0);
    vt[3] = mk(100, 100, 100, 100, 100, 100, 100, 100, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) d_in[k] = 8'd0;

    // Reset state.
    cyc(3);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset dut%0d {ready,ps,pwm}", i), {rdy_v[i], ps_v[i], pwm_v[i]}, 6'b100000);
    end
    reset  = 1'b0;
    chk_en = 1'b1;

    // Table: high-tick counts per period and rising position for the aligned instance.
    for (int v = 0; v < 4; v++) begin
      send(vt[v].d[0], vt[v].d[1], vt[v].d[2], vt[v].d[3]);
      wait_ps(2, 2);
      cyc(2);
      for (int i = 0; i < NI; i++) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("vec%0d dut%0d ch%0d high clks", v, i, k), last_cnt[i][k], vt[v].hi[k] * P_DIV[i]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        check($sformatf("vec%0d dut0 ch%0d rise pos", v, k), last_rise[0][k], vt[v].rise[k]);
      end
    end
    check("dut0 period clks", last_len[0], 255);
    check("dut1 period clks", last_len[1], 255);
    check("dut2 period clks", last_len[2], 1020);

    // Mid-period update: old width until the boundary, new width afterwards.
    send(128, 128, 128, 128);
    wait_ps(0, 2);
    cyc(100);
    send(32, 32, 32, 32);
    check("ready low after mid-period xfer", rdy_v[0], 0);
    wait_ps(0, 1);
    cyc(2);
    check("ready back after boundary", rdy_v[0], 1);
    for (int k = 0; k < 4; k++) check($sformatf("period of update ch%0d", k), last_cnt[0][k], 128);
    wait_ps(0, 1);
    cyc(2);
    for (int k = 0; k < 4; k++) check($sformatf("period after update ch%0d", k), last_cnt[0][k], 32);

    // Valid held with changing data: one acceptance per period.
    nacc     = 0;
    last_val = 0;
    d_valid  = 1'b1;
    for (int c = 0; c < 600; c++) begin
      v8 = (c * 7 + 3) % 256;
      for (int k = 0; k < 4; k++) d_in[k] = 8'(v8);
      if (rdy_v[0]) begin
        nacc++;
        last_val = v8;
        $display("xfer t=%0t held-valid duty=%0d", $time, v8);
      end
      cyc(1);
    end
    d_valid = 1'b0;
    check("held-valid acceptances in 600 clks", nacc, 3);
    wait_ps(0, 2);
    cyc(2);
    check("held-valid last accepted duty applied", last_cnt[0][0], last_val);

    // Staggered phases: with phase = cnt + off, channel k turns on at cnt = 255 - off.
    send(64, 64, 64, 64);
    wait_ps(1, 2);
    cyc(2);
    check("stagger R rise", last_rise[1][0], 0);
    check("stagger G rise", last_rise[1][1], 191);
    check("stagger B rise", last_rise[1][2], 127);
    check("stagger W rise", last_rise[1][3], 63);
    for (int k = 0; k < 4; k++) check($sformatf("stagger ch%0d width", k), last_cnt[1][k], 64);

    // out_en low for 10 clks mid-period.
    cyc(50);
    check("staggered outputs active before gating", pwm_v[1] != 4'b0000, 1);
    out_en = 1'b0;
    cyc(1);
    for (int i = 0; i < NI; i++) check($sformatf("out_en low dut%0d pwm", i), pwm_v[i], 0);
    cyc(9);
    out_en = 1'b1;
    wait_ps(0, 2);
    cyc(2);
    check("period unaffected by out_en", last_len[0], 255);

    // Reset mid-period with a transfer pending.
    send(170, 170, 170, 170);
    cyc(5);
    reset = 1'b1;
    cyc(1);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("mid reset dut%0d pwm", i), pwm_v[i], 0);
      check($sformatf("mid reset dut%0d ready", i), rdy_v[i], 1);
    end
    cyc(2);
    reset = 1'b0;
    wait_ps(0, 2);
    cyc(2);
    for (int k = 0; k < 4; k++) check($sformatf("after reset ch%0d high clks", k), last_cnt[0][k], 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      d_valid = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) begin
        v8 = $urandom_range(0, 5);
        d_in[k] = (v8 == 0) ? 8'd0 : (v8 == 1) ? 8'd255 : 8'($urandom_range(0, 255));
      end
      out_en = ($urandom_range(0, 19) != 0);
      if (d_valid && rdy_v[0]) begin
        $display("xfer t=%0t random duty r/g/b/w=%0d/%0d/%0d/%0d", $time, d_in[0], d_in[1], d_in[2], d_in[3]);
      end
      cyc(1);
    end
    d_valid = 1'b0;
    out_en  = 1'b1;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
